// File: rtl/riscv_dmem.sv
// Hart data memory: combinational hart read, byte-lane stores, sticky store fault and a debug port.
// Optional macro DMEM_CLEAR_EN adds a post-reset sweep that zeroes every word while busy is high.
module riscv_dmem #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic            mem_write,
    input  logic [1:0]      mem_size,
    output logic [XLEN-1:0] mem_read,
    output logic            busy,
    output logic            fault,
    input  logic            fault_clr,
    input  logic            dbg_en,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    input  logic            dbg_we,
    output logic [XLEN-1:0] dbg_rdata
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] dbg_rdata_q;
    logic            fault_q;

    logic            run;
    logic            clearing;
    logic [AW-1:0]   clear_idx;

`ifdef DMEM_CLEAR_EN
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        clearing = 1'b0;
        run      = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                busy     = 1'b1;
                clearing = 1'b1;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign clear_idx = cnt_q;
`else
    assign busy      = 1'b0;
    assign clearing  = 1'b0;
    assign run       = 1'b1;
    assign clear_idx = '0;
`endif

    // Hart request decode; the word index deliberately ignores the upper
    // address bits, which only feed the range check.
    logic [AW-1:0]   hart_idx;
    logic            in_range;
    logic            misaligned;
    logic            store_bad;
    logic            hart_req;
    logic            hart_we;
    logic            fault_set;
    logic [NB-1:0]   hart_be;
    logic [XLEN-1:0] hart_wdata;

    assign hart_idx   = mem_addr[AW+1:2];
    assign in_range   = ~|mem_addr[XLEN-1:AW+2];
    assign misaligned = ((mem_size == 2'b01) && mem_addr[0]) ||
                        ((mem_size == 2'b10) && (mem_addr[1:0] != 2'b00));
    assign store_bad  = misaligned || (mem_size == 2'b11) || !in_range;
    assign hart_req   = run && !dbg_en && mem_write;
    assign hart_we    = hart_req && !store_bad;
    assign fault_set  = hart_req && store_bad;

    // Store data arrives lane-0 aligned; replicate it so every lane the
    // enables select already carries the right byte.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign hart_wdata[gi*8 +: 8] =
                (mem_size == 2'b00) ? mem_data[7:0] :
                (mem_size == 2'b01) ? mem_data[(gi % 2)*8 +: 8] :
                                      mem_data[gi*8 +: 8];
            assign hart_be[gi] =
                (mem_size == 2'b10) ||
                ((mem_size == 2'b01) && (mem_addr[1] == 1'(gi / 2))) ||
                ((mem_size == 2'b00) && (mem_addr[1:0] == 2'(gi)));
        end
    endgenerate

    // Single write port; priority is sweep, then debug, then hart.
    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [XLEN-1:0] wr_data;
    logic [NB-1:0]   wr_be;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = dbg_addr;
        wr_data = dbg_wdata;
        wr_be   = '1;
        if (clearing) begin
            wr_en   = 1'b1;
            wr_idx  = clear_idx;
            wr_data = '0;
        end else if (dbg_en && dbg_we) begin
            wr_en = 1'b1;
        end else if (hart_we) begin
            wr_en   = 1'b1;
            wr_idx  = hart_idx;
            wr_data = hart_wdata;
            wr_be   = hart_be;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Non-blocking read gives read-first behaviour on a same-address dbg_we.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_rdata_q <= '0;
        end else begin
            dbg_rdata_q <= mem_q[dbg_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end else if (fault_clr) begin
            fault_q <= 1'b0;
        end
    end

    assign mem_read  = (run && !dbg_en && in_range) ? mem_q[hart_idx] : '0;
    assign dbg_rdata = dbg_rdata_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_riscv_dmem.sv
// Self-checking bench for riscv_dmem (DEPTH=16) against a byte-array reference model.
// The clear-sweep scenario runs only when DMEM_CLEAR_EN is defined for the build.
module tb_riscv_dmem;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int NBYTES = DEPTH * 4;
`ifdef DMEM_CLEAR_EN
    localparam logic EXP_BUSY_RST = 1'b1;
`else
    localparam logic EXP_BUSY_RST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [XLEN-1:0] mem_addr = '0;
    logic [XLEN-1:0] mem_data = '0;
    logic            mem_write = 1'b0;
    logic [1:0]      mem_size = 2'b10;
    logic [XLEN-1:0] mem_read;
    logic            busy;
    logic            fault;
    logic            fault_clr = 1'b0;
    logic            dbg_en = 1'b0;
    logic [AW-1:0]   dbg_addr = '0;
    logic [XLEN-1:0] dbg_wdata = '0;
    logic            dbg_we = 1'b0;
    logic [XLEN-1:0] dbg_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: memory as plain bytes plus the sticky fault bit.
    logic [7:0] mb [NBYTES];
    logic       m_fault = 1'b0;

    riscv_dmem #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_write (mem_write),
        .mem_size  (mem_size),
        .mem_read  (mem_read),
        .busy      (busy),
        .fault     (fault),
        .fault_clr (fault_clr),
        .dbg_en    (dbg_en),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_we    (dbg_we),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [5:0] b;
        if (a >= 32'(NBYTES)) return 32'h0;
        b = a[5:0] & 6'h3C;
        return {mb[b + 6'd3], mb[b + 6'd2], mb[b + 6'd1], mb[b]};
    endfunction

    // Returns 1 when the store is rejected; otherwise writes 1, 2 or 4 bytes.
    function automatic logic model_store(input logic [31:0] a, input logic [31:0] d,
                                         input logic [1:0] sz);
        int unsigned n;
        logic bad;
        n = 1 << sz;
        bad = (sz == 2'd3) || ((a % n) != 0) || (a >= 32'(NBYTES));
        if (!bad) begin
            for (int k = 0; k < int'(n); k++) begin
                mb[a[5:0] + 6'(k)] = d[8*k +: 8];
            end
        end
        return bad;
    endfunction

    function automatic void model_dbg_write(input int idx, input logic [31:0] d);
        for (int k = 0; k < 4; k++) mb[6'(idx*4 + k)] = d[8*k +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_write(input int idx, input logic [31:0] d);
        dbg_en    = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = AW'(idx);
        dbg_wdata = d;
        tick();
        dbg_we = 1'b0;
        dbg_en = 1'b0;
        model_dbg_write(idx, d);
    endtask

    task automatic hart_store(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, input logic clr);
        logic bad;
        mem_addr  = a;
        mem_data  = d;
        mem_size  = sz;
        mem_write = 1'b1;
        fault_clr = clr;
        bad = model_store(a, d, sz);
        if (bad) m_fault = 1'b1;
        else if (clr) m_fault = 1'b0;
        tick();
        mem_write = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== EXP_BUSY_RST) begin
            n_bad++;
            $display("FAIL reset_busy: got %b expected %b", busy, EXP_BUSY_RST);
        end
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fault: got %b expected 0", fault);
        end
        n_cmp++;
        if (dbg_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_dbg_rdata: got %h expected 00000000", dbg_rdata);
        end
        rst = 1'b0;
        m_fault = 1'b0;
        $display("test_reset done");
    endtask

`ifdef DMEM_CLEAR_EN
    task automatic test_clear();
        int cyc;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != DEPTH) begin
            n_bad++;
            $display("FAIL clear_busy_len: got %0d cycles expected %0d", cyc, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) dbg_write(i, $urandom | 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_addr  = 32'h1;
        mem_size  = 2'b10;
        mem_write = 1'b1;
        repeat (5) tick();
        mem_write = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_busy_cyc5: got %b expected 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != DEPTH) begin
            n_bad++;
            $display("FAIL clear_restart_len: got %0d cycles expected %0d", cyc, DEPTH);
        end
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_busy_store_fault: got %b expected 0", fault);
        end
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            dbg_addr = AW'(i);
            tick();
            n_cmp++;
            if (dbg_rdata !== model_word(32'(i*4))) begin
                n_bad++;
                $display("FAIL clear_word%0d: got %h expected %h", i, dbg_rdata,
                         model_word(32'(i*4)));
            end
        end
        $display("test_clear done");
    endtask
`endif

    task automatic test_preload();
        for (int i = 0; i < DEPTH; i++) dbg_write(i, $urandom);
        for (int i = 0; i < DEPTH; i += 5) begin
            dbg_addr = AW'(i);
            tick();
            n_cmp++;
            if (dbg_rdata !== model_word(32'(i*4))) begin
                n_bad++;
                $display("FAIL preload_word%0d: got %h expected %h", i, dbg_rdata,
                         model_word(32'(i*4)));
            end
        end
        $display("test_preload done");
    endtask

    task automatic test_lanes();
        clear_fault();
        hart_store(32'h20, 32'h11223344, 2'b10, 1'b0);
        hart_store(32'h22, 32'h000000AA, 2'b00, 1'b0);
        hart_store(32'h20, 32'h0000BEEF, 2'b01, 1'b0);
        mem_addr = 32'h20;
        #1;
        n_cmp++;
        if (mem_read !== 32'h11AABEEF) begin
            n_bad++;
            $display("FAIL lanes_merge: got %h expected 11aabeef", mem_read);
        end
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL lanes_fault: got %b expected 0", fault);
        end
        $display("test_lanes done");
    endtask

    task automatic test_misaligned();
        hart_store(32'h21, 32'hDEADBEEF, 2'b10, 1'b0);
        n_cmp++;
        if (fault !== 1'b1) begin
            n_bad++;
            $display("FAIL misaligned_word_fault: got %b expected 1", fault);
        end
        hart_store(32'h23, 32'h00005555, 2'b01, 1'b0);
        hart_store(32'h20, 32'h77777777, 2'b11, 1'b0);
        mem_addr = 32'h20;
        #1;
        n_cmp++;
        if (mem_read !== 32'h11AABEEF) begin
            n_bad++;
            $display("FAIL misaligned_unchanged: got %h expected 11aabeef", mem_read);
        end
        clear_fault();
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL misaligned_clr: got %b expected 0", fault);
        end
        hart_store(32'h23, 32'h00001234, 2'b01, 1'b1);
        n_cmp++;
        if (fault !== 1'b1) begin
            n_bad++;
            $display("FAIL misaligned_set_beats_clr: got %b expected 1", fault);
        end
        $display("test_misaligned done");
    endtask

    task automatic test_range();
        clear_fault();
        hart_store(32'h40, 32'hFFFF0000, 2'b10, 1'b0);
        n_cmp++;
        if (fault !== 1'b1) begin
            n_bad++;
            $display("FAIL range_fault: got %b expected 1", fault);
        end
        mem_addr = 32'h40;
        #1;
        n_cmp++;
        if (mem_read !== 32'h0) begin
            n_bad++;
            $display("FAIL range_read: got %h expected 00000000", mem_read);
        end
        mem_addr = 32'h0;
        #1;
        n_cmp++;
        if (mem_read !== model_word(32'h0)) begin
            n_bad++;
            $display("FAIL range_no_alias: got %h expected %h", mem_read, model_word(32'h0));
        end
        $display("test_range done");
    endtask

    task automatic test_rdw();
        logic bad;
        dbg_write(2, 32'h0BADBEEF);
        mem_addr  = 32'h8;
        mem_data  = 32'hCAFEF00D;
        mem_size  = 2'b10;
        mem_write = 1'b1;
        #3;
        n_cmp++;
        if (mem_read !== 32'h0BADBEEF) begin
            n_bad++;
            $display("FAIL rdw_old: got %h expected 0badbeef", mem_read);
        end
        bad = model_store(32'h8, 32'hCAFEF00D, 2'b10);
        tick();
        mem_write = 1'b0;
        n_cmp++;
        if (mem_read !== 32'hCAFEF00D || bad) begin
            n_bad++;
            $display("FAIL rdw_new: got %h expected cafef00d", mem_read);
        end
        $display("test_rdw done");
    endtask

    task automatic test_debug();
        logic [31:0] old_w;
        clear_fault();
        old_w     = model_word(32'hC);
        dbg_en    = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 4'd3;
        dbg_wdata = 32'h12345678;
        mem_addr  = 32'hC;
        mem_data  = 32'hDEADBEEF;
        mem_size  = 2'b10;
        mem_write = 1'b1;
        #1;
        n_cmp++;
        if (mem_read !== 32'h0) begin
            n_bad++;
            $display("FAIL debug_read_blocked: got %h expected 00000000", mem_read);
        end
        tick();
        dbg_we    = 1'b0;
        mem_write = 1'b0;
        model_dbg_write(3, 32'h12345678);
        n_cmp++;
        if (dbg_rdata !== old_w) begin
            n_bad++;
            $display("FAIL debug_read_first: got %h expected %h", dbg_rdata, old_w);
        end
        tick();
        n_cmp++;
        if (dbg_rdata !== 32'h12345678) begin
            n_bad++;
            $display("FAIL debug_rdata: got %h expected 12345678", dbg_rdata);
        end
        dbg_en = 1'b0;
        #1;
        n_cmp++;
        if (mem_read !== 32'h12345678) begin
            n_bad++;
            $display("FAIL debug_hart_dropped: got %h expected 12345678", mem_read);
        end
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL debug_no_fault: got %b expected 0", fault);
        end
        $display("test_debug done");
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp_r;
        logic [1:0]  sz;
        logic        w, clr, bad;
        for (int it = 0; it < 200; it++) begin
            a = 32'($urandom_range(0, 95));
            if ($urandom_range(0, 9) == 0) a = a | 32'h1000_0000;
            d   = $urandom;
            sz  = 2'($urandom_range(0, 3));
            w   = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0);
            mem_addr  = a;
            mem_data  = d;
            mem_size  = sz;
            mem_write = w;
            fault_clr = clr;
            exp_r = model_word(a);
            #3;
            n_cmp++;
            if (mem_read !== exp_r) begin
                n_bad++;
                $display("FAIL random_read it=%0d addr=%h: got %h expected %h", it, a, mem_read, exp_r);
            end
            bad = w ? model_store(a, d, sz) : 1'b0;
            if (bad) m_fault = 1'b1;
            else if (clr) m_fault = 1'b0;
            tick();
            mem_write = 1'b0;
            fault_clr = 1'b0;
            n_cmp++;
            if (fault !== m_fault) begin
                n_bad++;
                $display("FAIL random_fault it=%0d addr=%h size=%0d: got %b expected %b",
                         it, a, sz, fault, m_fault);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
`ifdef DMEM_CLEAR_EN
        test_clear();
`endif
        test_preload();
        test_lanes();
        test_misaligned();
        test_range();
        test_rdw();
        test_debug();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
